// File: rtl/alu_sequencer.sv
// alu_sequencer: multicycle request/response controller that feeds a combinational ALU and owns the Z register
// Ports:
//   i_clock, i_clear (sync active-low reset)
//   request : i_req_valid, o_req_ready, i_req_opcode[4:0], i_req_ra[31:0], i_req_rb[31:0]
//   ALU     : o_alu_a[31:0], o_alu_b[31:0], o_alu_op[4:0] (registered, held through EXEC), i_alu_rc[63:0]
//   response: o_rsp_valid, i_rsp_ready, o_zhi[31:0], o_zlo[31:0], o_rsp_err
//   status  : o_busy, o_op_count[15:0]
module alu_sequencer #(
  parameter int ALU_CYCLES = 1,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic        i_clock,
  input  logic        i_clear,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [4:0]  i_req_opcode,
  input  logic [31:0] i_req_ra,
  input  logic [31:0] i_req_rb,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic [4:0]  o_alu_op,
  input  logic [63:0] i_alu_rc,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_zhi,
  output logic [31:0] o_zlo,
  output logic        o_rsp_err,
  output logic        o_busy,
  output logic [15:0] o_op_count
);
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_alu_a, r_alu_b, r_zhi, r_zlo;
  logic [4:0]  r_alu_op;
  logic        r_rsp_valid, r_rsp_err;
  logic [15:0] r_op_count;
  logic        w_legal, w_div0;
  logic [7:0]  w_cnt_init;
  always_comb begin
    w_legal = i_req_opcode inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                                   5'b01001, 5'b01010, 5'b01011, OP_MUL, OP_DIV, 5'b10001, 5'b10010};
    w_div0 = (i_req_opcode == OP_DIV) && (i_req_rb == 32'd0);
    // cnt is loaded with N-1 so the capture lands exactly N edges after accept
    w_cnt_init = (i_req_opcode == OP_MUL) ? 8'(MUL_CYCLES - 1) :
                 (i_req_opcode == OP_DIV) ? 8'(DIV_CYCLES - 1) : 8'(ALU_CYCLES - 1);
  end
  always_ff @(posedge i_clock) begin
    if (!i_clear) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_alu_a     <= 32'd0;
      r_alu_b     <= 32'd0;
      r_alu_op    <= 5'd0;
      r_zhi       <= 32'd0;
      r_zlo       <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_op_count  <= 16'd0;
    end else begin
      case (r_state)
        IDLE: if (i_req_valid) begin
          if (w_legal && !w_div0) begin
            r_alu_a  <= i_req_ra;
            r_alu_b  <= i_req_rb;
            r_alu_op <= i_req_opcode;
            r_cnt    <= w_cnt_init;
            r_state  <= EXEC;
          end else begin
            // rejected requests skip the ALU and answer immediately with a zero result
            r_zhi       <= 32'd0;
            r_zlo       <= 32'd0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        EXEC: if (r_cnt != 8'd0) begin
          r_cnt <= r_cnt - 8'd1;
        end else begin
          r_zhi       <= i_alu_rc[63:32];
          r_zlo       <= i_alu_rc[31:0];
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: if (i_rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_op_count  <= r_op_count + 16'd1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_req_ready = (r_state == IDLE);
  assign o_busy      = (r_state != IDLE);
  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_op    = r_alu_op;
  assign o_zhi       = r_zhi;
  assign o_zlo       = r_zlo;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_op_count  = r_op_count;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized and directed checking of alu_sequencer against a transaction-level model
module tb_alu_sequencer;
  logic        clk = 0, clear = 0, req_valid = 0, rsp_ready = 0;
  logic [4:0]  req_opcode = 0;
  logic [31:0] req_ra = 0, req_rb = 0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] alu_a, alu_b, zhi, zlo;
  logic [4:0]  alu_op;
  logic [63:0] alu_rc;
  logic [15:0] op_count;
  int checks = 0, failures = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;
  function automatic logic [63:0] alu_f(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] r;
    logic signed [63:0] sa, sb;
    logic [4:0] s;
    s = b[4:0];
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    r = 64'd0;
    case (op)
      5'd3:  r = {32'd0, a + b};
      5'd4:  r = {32'd0, a - b};
      5'd5:  r = {32'd0, a & b};
      5'd6:  r = {32'd0, a | b};
      5'd7:  r = {32'd0, a >> s};
      5'd8:  r = {32'd0, 32'($signed(a) >>> s)};
      5'd9:  r = {32'd0, a << s};
      5'd10: r = {32'd0, (a >> s) | (a << (6'd32 - {1'b0, s}))};
      5'd11: r = {32'd0, (a << s) | (a >> (6'd32 - {1'b0, s}))};
      5'd15: r = 64'(sa * sb);
      5'd16: r = (b == 0) ? 64'd0 : {32'(sa % sb), 32'(sa / sb)};
      5'd17: r = {32'd0, 32'd0 - a};
      5'd18: r = {32'd0, ~a};
      default: r = 64'd0;
    endcase
    return r;
  endfunction
  function automatic bit legal(logic [4:0] op);
    return op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18};
  endfunction
  function automatic int ncyc(logic [4:0] op);
    return op == 5'd15 ? 4 : op == 5'd16 ? 8 : 1;
  endfunction
  assign alu_rc = alu_f(alu_op, alu_a, alu_b);
  alu_sequencer dut (
    .i_clock(clk), .i_clear(clear), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_opcode(req_opcode), .i_req_ra(req_ra), .i_req_rb(req_rb),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op), .i_alu_rc(alu_rc),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_zhi(zhi), .o_zlo(zlo),
    .o_rsp_err(rsp_err), .o_busy(busy), .o_op_count(op_count)
  );
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  // Transaction model: an accepted op is due N edges later; a result is held until taken.
  int t = 0, m_due = 0;
  bit m_pend = 0, m_valid = 0, m_err = 0;
  logic [31:0] m_a = 0, m_b = 0, m_zhi = 0, m_zlo = 0;
  logic [4:0] m_op = 0;
  logic [15:0] m_cnt = 0;
  always @(posedge clk) begin
    t <= t + 1;
    if (!clear) begin
      m_pend <= 0; m_valid <= 0; m_err <= 0; m_zhi <= 0; m_zlo <= 0;
      m_cnt <= 0; m_a <= 0; m_b <= 0; m_op <= 0;
    end else if (m_valid) begin
      if (rsp_ready) begin m_valid <= 0; m_cnt <= m_cnt + 1; end
    end else if (m_pend) begin
      if (t == m_due) begin
        {m_zhi, m_zlo} <= alu_f(m_op, m_a, m_b);
        m_err <= 0; m_valid <= 1; m_pend <= 0;
      end
    end else if (req_valid) begin
      if (legal(req_opcode) && !(req_opcode == 5'd16 && req_rb == 0)) begin
        m_a <= req_ra; m_b <= req_rb; m_op <= req_opcode;
        m_pend <= 1; m_due <= t + ncyc(req_opcode);
      end else begin
        m_zhi <= 0; m_zlo <= 0; m_err <= 1; m_valid <= 1;
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("req_ready", 64'(req_ready), 64'(!(m_pend || m_valid)));
    chk("busy", 64'(busy), 64'(m_pend || m_valid));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    chk("rsp_err", 64'(rsp_err), 64'(m_err));
    chk("zhi", 64'(zhi), 64'(m_zhi));
    chk("zlo", 64'(zlo), 64'(m_zlo));
    chk("op_count", 64'(op_count), 64'(m_cnt));
    chk("alu_a", 64'(alu_a), 64'(m_a));
    chk("alu_b", 64'(alu_b), 64'(m_b));
    chk("alu_op", 64'(alu_op), 64'(m_op));
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    req_valid = 1; req_opcode = op; req_ra = a; req_rb = b;
    step;
    req_valid = 0;
  endtask
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 300) begin step; lat++; end
    if (!rsp_valid) chk("rsp_timeout", 64'd0, 64'd1);
  endtask
  logic [4:0] ops[13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18};
  initial begin
    int lat;
    step;
    chk_en = 1;
    step;
    clear = 1;
    step;
    chk("reset_ready", 64'(req_ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_valid", 64'(rsp_valid), 64'd0);
    chk("reset_z", {zhi, zlo}, 64'd0);
    chk("reset_count", 64'(op_count), 64'd0);
    rsp_ready = 1;
    issue(5'd3, 32'd5, 32'd7);
    wait_rsp(lat);
    chk("add_lat", 64'(lat), 64'd1);
    chk("add_z", {zhi, zlo}, 64'd12);
    chk("add_err", 64'(rsp_err), 64'd0);
    step;
    chk("add_count", 64'(op_count), 64'd1);
    rsp_ready = 0;
    issue(5'd15, 32'hFFFFFFFF, 32'd2);
    wait_rsp(lat);
    chk("mul_lat", 64'(lat), 64'd4);
    chk("mul_z", {zhi, zlo}, 64'hFFFFFFFF_FFFFFFFE);
    rsp_ready = 1;
    step;
    rsp_ready = 0;
    issue(5'd16, 32'd9, 32'd0);
    wait_rsp(lat);
    chk("div0_lat", 64'(lat), 64'd0);
    chk("div0_err", 64'(rsp_err), 64'd1);
    chk("div0_z", {zhi, zlo}, 64'd0);
    chk("div0_alu", {27'd0, alu_op, alu_b}, {27'd0, 5'd15, 32'd2});
    rsp_ready = 1;
    step;
    rsp_ready = 0;
    issue(5'd31, 32'd1, 32'd1);
    wait_rsp(lat);
    chk("illegal_lat", 64'(lat), 64'd0);
    chk("illegal_err", 64'(rsp_err), 64'd1);
    chk("illegal_alu", {27'd0, alu_op, alu_a}, {27'd0, 5'd15, 32'hFFFFFFFF});
    rsp_ready = 1;
    step;
    rsp_ready = 0;
    chk("err_count", 64'(op_count), 64'd4);
    issue(5'd16, 32'd100, 32'd7);
    wait_rsp(lat);
    chk("div_lat", 64'(lat), 64'd8);
    chk("div_z", {zhi, zlo}, {32'd2, 32'd14});
    req_valid = 1; req_opcode = 5'd3;
    for (int i = 0; i < 5; i++) begin
      step;
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_hold", {31'd0, rsp_valid, zlo}, {31'd0, 1'b1, 32'd14});
    end
    rsp_ready = 1;
    step;
    req_valid = 0;
    chk("bp_release", {46'd0, req_ready, rsp_valid, op_count}, {46'd0, 1'b1, 1'b0, 16'd5});
    rsp_ready = 0;
    issue(5'd15, 32'd3, 32'd4);
    step;
    step;
    clear = 0;
    step;
    clear = 1;
    chk("abort_state", {46'd0, req_ready, rsp_valid, op_count}, {46'd0, 1'b1, 1'b0, 16'd0});
    chk("abort_regs", {alu_op, alu_a, zlo}, 69'd0);
    rsp_ready = 1;
    issue(5'd3, 32'd2, 32'd3);
    wait_rsp(lat);
    chk("post_abort_z", {zhi, zlo}, 64'd5);
    step;
    chk("post_abort_count", 64'(op_count), 64'd1);
    for (int i = 0; i < 3000; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_opcode = ($urandom_range(0, 15) < 11) ? ops[$urandom_range(0, 12)] : 5'($urandom);
      req_ra = $urandom;
      req_rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      rsp_ready = $urandom_range(0, 2) != 0;
      clear = $urandom_range(0, 199) != 0;
      step;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multicycle controller wrapped around the combinational 32-bit ALU (ADD/SUB/AND/OR/SHR/SHRA/SHL/ROR/ROL/MUL/DIV/NEG/NOT, 5-bit opcode, 64-bit result).
- Accepts one operation per request handshake and registers operands and opcode onto the ALU inputs.
- Holds those inputs stable for a per-class number of cycles, so MUL/DIV may be timed as multicycle paths.
- Captures the 64-bit result into ZHI/ZLO and returns it through a response handshake.
- Sits between the CPU control unit and the ALU; it owns the Z register.

Parameters:
- ALU_CYCLES, 1, EXEC cycles for all single-width ops (legal range 1..255).
- MUL_CYCLES, 4, EXEC cycles for MUL (1..255).
- DIV_CYCLES, 8, EXEC cycles for DIV (1..255).

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept.
- req_opcode  in  5  ALU opcode.
- req_ra  in  32  operand A.
- req_rb  in  32  operand B.
- alu_a  out  32  registered operand to ALU Ra.
- alu_b  out  32  registered operand to ALU Rb.
- alu_op  out  5  registered opcode to ALU.
- alu_rc  in  64  ALU result.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- zhi  out  32  result bits 63:32.
- zlo  out  32  result bits 31:0.
- rsp_err  out  1  illegal opcode or divide-by-zero.
- busy  out  1  high whenever state is not IDLE.
- op_count  out  16  completed responses, wraps at 16'hFFFF -> 0.

Behaviour:
- Reset: on a rising edge with clear=0, all of the following happen regardless of state, aborting any operation in flight:
  - state=IDLE;
  - alu_a, alu_b, alu_op, zhi, zlo, op_count = 0;
  - rsp_valid=0, rsp_err=0, cnt=0.
- Legal opcodes: 00011, 00100, 00101, 00110, 00111, 01000, 01001, 01010, 01011, 01111 (MUL), 10000 (DIV), 10001, 10010. All other codes are illegal.
- States: IDLE, EXEC, RESP.
- req_ready = (state==IDLE). busy = (state!=IDLE). Both are combinational from state.
- IDLE, on req_valid at the edge:
  - Legal opcode, not DIV-by-zero:
    - alu_a<=req_ra, alu_b<=req_rb, alu_op<=req_opcode;
    - cnt<=N-1, where N = MUL_CYCLES for MUL, DIV_CYCLES for DIV, ALU_CYCLES otherwise;
    - go to EXEC.
  - Illegal opcode, or DIV with req_rb==0:
    - zhi<=0, zlo<=0, rsp_err<=1, rsp_valid<=1;
    - go to RESP (one-edge latency);
    - alu_* are not updated.
- EXEC:
  - alu_* are held constant.
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: zhi<=alu_rc[63:32], zlo<=alu_rc[31:0], rsp_err<=0, rsp_valid<=1, go to RESP.
  - rsp_valid therefore rises exactly N edges after the accept edge.
  - req_valid is ignored.
- RESP:
  - rsp_valid, zhi, zlo and rsp_err are held until rsp_ready=1 at an edge.
  - On that edge: rsp_valid<=0, op_count<=op_count+1, go to IDLE.
  - zhi/zlo keep their value after the handshake, until the next capture or reset.
  - A new request cannot be accepted in the same cycle as the response handshake; minimum spacing is accept→RESP→IDLE→accept.
- alu_a/alu_b/alu_op retain their last values in IDLE and RESP.
- Result widths: zhi is taken verbatim from alu_rc; for single-width ops the ALU already drives the upper 32 bits to zero. No sign extension or modification is done here.
- Errored responses increment op_count like normal ones.

Test Plan:
1. Reset: clear=0 for 2 cycles, then 1. Required: req_ready=1, busy=0, rsp_valid=0, zhi=zlo=0, op_count=0.
2. ADD: Ra=5, Rb=7, opcode 00011, rsp_ready=1. Required: rsp_valid high 1 edge after accept (ALU_CYCLES=1), zlo=12, zhi=0, rsp_err=0, op_count=1.
3. MUL: Ra=32'hFFFFFFFF, Rb=2, opcode 01111. Required: alu_* stable for 4 cycles, rsp_valid at edge 4, {zhi,zlo} = ALU 64-bit product (zhi=32'hFFFFFFFF, zlo=32'hFFFFFFFE signed).
4. DIV by zero and illegal opcode: opcode 10000 with Rb=0, then opcode 11111. Required for each: rsp_valid 1 edge after accept, rsp_err=1, zhi=zlo=0, alu_* unchanged from the prior op.
5. Backpressure: DIV with Ra=100, Rb=7, rsp_ready=0 for 5 cycles after rsp_valid. Required: outputs held, req_ready=0 despite req_valid=1; after rsp_ready=1, IDLE on the next edge and op_count increments by exactly 1.
6. Reset mid-op: clear=0 during the 3rd EXEC cycle of MUL. Required: state IDLE at the next edge, rsp_valid never asserted, all outputs at reset values; a new ADD afterwards completes normally.
